// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: op codes, cycle-counter width and FSM states.
// Imported by the multiply/divide unit, the D-stage decoder and the hazard logic.
package mdu_unit_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MDU_CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // Ops that occupy the unit for several cycles.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op >= 3'(MDU_MULT)) && (op <= 3'(MDU_DIVU));
    endfunction

endpackage

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit for the E stage: owns HI/LO, runs
// mult/multu/div/divu with fixed latency and serves mfhi/mflo via mdu_out.
module mdu_unit
    import mdu_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter bit CHECK_ISSUE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] mdu_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [MDU_CNT_W-1:0] MULT_CNT = MDU_CNT_W'(MULT_CYCLES);
    localparam logic [MDU_CNT_W-1:0] DIV_CNT  = MDU_CNT_W'(DIV_CYCLES);

    mdu_state_e           state_reg, state_next;
    logic [MDU_CNT_W-1:0] cnt_reg, cnt_next;
    logic [31:0]          hi_reg, hi_next;
    logic [31:0]          lo_reg, lo_next;
    logic [31:0]          pend_hi_reg, pend_hi_next;
    logic [31:0]          pend_lo_reg, pend_lo_next;
    logic                 pend_wr_reg, pend_wr_next;

    mdu_op_e     op;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign op = mdu_op_e'(mdu_op);

    assign prod_s = 64'($signed(src_a) * $signed(src_b));
    assign prod_u = {32'd0, src_a} * {32'd0, src_b};

    assign div_zero = (src_b == 32'd0);
    assign div_ovf  = (src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF);

    // Guard the corner cases so the dividers never see /0 or the one overflowing pair.
    always_comb begin
        quo_s = 32'd0;
        rem_s = 32'd0;
        quo_u = 32'd0;
        rem_u = 32'd0;
        if (div_ovf) begin
            quo_s = 32'h8000_0000;
        end else if (!div_zero) begin
            quo_s = 32'($signed(src_a) / $signed(src_b));
            rem_s = 32'($signed(src_a) % $signed(src_b));
        end
        if (!div_zero) begin
            quo_u = src_a / src_b;
            rem_u = src_a % src_b;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            hi_reg      <= 32'd0;
            lo_reg      <= 32'd0;
            pend_hi_reg <= 32'd0;
            pend_lo_reg <= 32'd0;
            pend_wr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            hi_reg      <= hi_next;
            lo_reg      <= lo_next;
            pend_hi_reg <= pend_hi_next;
            pend_lo_reg <= pend_lo_next;
            pend_wr_reg <= pend_wr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        hi_next      = hi_reg;
        lo_next      = lo_reg;
        pend_hi_next = pend_hi_reg;
        pend_lo_next = pend_lo_reg;
        pend_wr_next = pend_wr_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        MDU_MULT: begin
                            {pend_hi_next, pend_lo_next} = prod_s;
                            pend_wr_next = 1'b1;
                            cnt_next     = MULT_CNT;
                        end
                        MDU_MULTU: begin
                            {pend_hi_next, pend_lo_next} = prod_u;
                            pend_wr_next = 1'b1;
                            cnt_next     = MULT_CNT;
                        end
                        MDU_DIV: begin
                            pend_hi_next = rem_s;
                            pend_lo_next = quo_s;
                            pend_wr_next = !div_zero;
                            cnt_next     = DIV_CNT;
                        end
                        MDU_DIVU: begin
                            pend_hi_next = rem_u;
                            pend_lo_next = quo_u;
                            pend_wr_next = !div_zero;
                            cnt_next     = DIV_CNT;
                        end
                        MDU_MTHI: hi_next = src_a;
                        MDU_MTLO: lo_next = src_a;
                        default: ;
                    endcase
                    if (is_long_op(mdu_op)) begin
                        state_next = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                // Any start seen here is dropped; the in-flight result wins.
                if (cnt_reg == MDU_CNT_W'(1)) begin
                    if (pend_wr_reg) begin
                        hi_next = pend_hi_reg;
                        lo_next = pend_lo_reg;
                    end
                    cnt_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    cnt_next = cnt_reg - MDU_CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy    = (state_reg == ST_BUSY);
    assign hi      = hi_reg;
    assign lo      = lo_reg;
    assign mdu_out = rd_sel ? hi_reg : lo_reg;

    always_ff @(posedge clk) begin
        if (CHECK_ISSUE && !reset) begin
            assert (!(start && busy && mdu_op != 3'(MDU_NONE) && mdu_op != 3'(MDU_RSVD)))
                else $error("mdu_unit: op issued while busy");
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// Directed self-checking bench for mdu_unit: latency, HI/LO results,
// corner cases, ignored operand changes/spurious starts and mid-op reset.
module tb_mdu_unit;
    import mdu_unit_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  mdu_op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        rd_sel;
    logic        busy;
    logic [31:0] mdu_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks   = 0;
    int failures = 0;

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10),
        .CHECK_ISSUE(1'b0)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .mdu_op (mdu_op),
        .src_a  (src_a),
        .src_b  (src_b),
        .rd_sel (rd_sel),
        .busy   (busy),
        .mdu_out(mdu_out),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start  = 1'b1;
        mdu_op = op;
        src_a  = a;
        src_b  = b;
        @(negedge clk);
        start  = 1'b0;
        mdu_op = 3'(MDU_NONE);
    endtask

    // Issue a long op, count busy cycles (bounded), then check latency and HI/LO.
    task automatic run_op(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input int n_exp, input logic [31:0] hi_exp,
                          input logic [31:0] lo_exp, input bit disturb);
        int n;
        issue(op, a, b);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (!busy) break;
            n++;
            if (disturb) begin
                src_a = $urandom;
                src_b = $urandom;
                if (n == 2) begin
                    start  = 1'b1;
                    mdu_op = 3'(MDU_DIV);
                end else begin
                    start  = 1'b0;
                    mdu_op = 3'(MDU_NONE);
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check_val({tag, "_lat"}, 64'(n), 64'(n_exp));
        check_val({tag, "_hi"}, 64'(hi), 64'(hi_exp));
        check_val({tag, "_lo"}, 64'(lo), 64'(lo_exp));
        rd_sel = 1'b1;
        #1 check_val({tag, "_mfhi"}, 64'(mdu_out), 64'(hi_exp));
        rd_sel = 1'b0;
        #1 check_val({tag, "_mflo"}, 64'(mdu_out), 64'(lo_exp));
        $display("op %-8s a=%08h b=%08h busy_cycles=%0d hi=%08h lo=%08h", tag, a, b, n, hi, lo);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        mdu_op = 3'(MDU_NONE);
        src_a  = 32'd0;
        src_b  = 32'd0;
        rd_sel = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Load nonzero state, then assert reset mid-cycle and check before any edge.
        issue(3'(MDU_MTHI), 32'h55, 32'd0);
        issue(3'(MDU_MTLO), 32'h66, 32'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check_val("rst_hi", 64'(hi), 64'h0);
        check_val("rst_lo", 64'(lo), 64'h0);
        check_val("rst_busy", 64'(busy), 64'h0);
        rd_sel = 1'b1;
        #1 check_val("rst_out_hi", 64'(mdu_out), 64'h0);
        rd_sel = 1'b0;
        #1 check_val("rst_out_lo", 64'(mdu_out), 64'h0);
        $display("reset mid-cycle hi=%08h lo=%08h busy=%0b", hi, lo, busy);
        @(negedge clk);
        reset = 1'b0;

        run_op("mult",  3'(MDU_MULT),  32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("multu", 3'(MDU_MULTU), 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0);
        run_op("div",   3'(MDU_DIV),   32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu",  3'(MDU_DIVU),  32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
        run_op("div_ovf", 3'(MDU_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);

        // mthi/mtlo are single-cycle and never raise busy.
        issue(3'(MDU_MTHI), 32'h11, 32'd0);
        check_val("mthi_busy", 64'(busy), 64'h0);
        check_val("mthi_hi", 64'(hi), 64'h11);
        issue(3'(MDU_MTLO), 32'h22, 32'd0);
        check_val("mtlo_busy", 64'(busy), 64'h0);
        check_val("mtlo_lo", 64'(lo), 64'h22);
        $display("mthi/mtlo hi=%08h lo=%08h busy=%0b", hi, lo, busy);

        // Reserved op must not touch anything.
        issue(3'(MDU_RSVD), 32'hDEAD_BEEF, 32'd1);
        check_val("rsvd_busy", 64'(busy), 64'h0);
        check_val("rsvd_hilo", {hi, lo}, 64'h0000_0011_0000_0022);
        $display("rsvd op hi=%08h lo=%08h busy=%0b", hi, lo, busy);

        run_op("divu_z", 3'(MDU_DIVU), 32'd100, 32'd0, 10, 32'h11, 32'h22, 1'b0);
        run_op("mult_dist", 3'(MDU_MULT), 32'h1234, 32'h10, 5, 32'd0, 32'h0001_2340, 1'b1);

        // Reset in cycle 3 of a div aborts it; the next mult runs normally.
        issue(3'(MDU_DIV), 32'd1000, 32'd7);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid_rst_busy", 64'(busy), 64'h0);
        check_val("mid_rst_hi", 64'(hi), 64'h0);
        check_val("mid_rst_lo", 64'(lo), 64'h0);
        $display("reset in div hi=%08h lo=%08h busy=%0b", hi, lo, busy);
        @(negedge clk);
        reset = 1'b0;
        run_op("mult_post", 3'(MDU_MULT), 32'd3, 32'hFFFF_FFFC, 5, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the E stage of the 5-stage MIPS pipeline.
- Owns the HI/LO registers and executes mult, multu, div, divu, mthi and mtlo.
- Drives the busy status from which the hazard logic forms its delayMDU stall input.
- Serves the E-stage result path for mfhi/mflo through mdu_out.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1-15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1-15)

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle strobe from E-stage control; mdu_op is valid while high
- mdu_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- src_a  in  32  forwarded rs operand
- src_b  in  32  forwarded rt operand
- rd_sel  in  1  0 selects LO, 1 selects HI, for mflo/mfhi
- busy  out  1  high while an operation is in flight
- mdu_out  out  32  rd_sel ? hi : lo (combinational)
- hi  out  32  architectural HI
- lo  out  32  architectural LO

Behaviour:
- Reset (asynchronous, active-high): hi=0, lo=0, busy=0, cnt=0, state=IDLE, pending regs=0. mdu_out follows as 0.
- State machine: two states.
  - IDLE: on edge with start=1 and mdu_op in 1..4, latch the result into pend_hi/pend_lo, load cnt with the op's cycle count, go to BUSY.
  - BUSY: decrement cnt every edge. On the edge where cnt==1, commit pend_hi/pend_lo into hi/lo, clear busy, go to IDLE.
- Latency: busy rises at the edge after start, stays high exactly MULT_CYCLES / DIV_CYCLES cycles, and hi/lo update on the same edge busy falls. An mfhi issued in the first cycle with busy=0 reads the new value.
- Arithmetic:
  - mult: signed 32x32 to 64 bits, {hi,lo}=product.
  - multu: unsigned 32x32 to 64 bits, {hi,lo}=product.
  - div: signed; lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - divu: unsigned; lo=quotient, hi=remainder.
  - Results are computed combinationally from src_a/src_b at start and latched, so operand changes after start are ignored.
- Divide by zero (src_b==0, div/divu): still busy for DIV_CYCLES; hi/lo left unchanged at commit.
- Signed overflow 0x80000000 / -1: lo=0x80000000, hi=0.
- mthi/mtlo, start=1 in IDLE: hi (or lo) <= src_a at that edge; busy stays 0.
- start while BUSY: the hazard unit stalls D and never issues this. If it happens anyway, the request is ignored, the in-flight op completes and hi/lo are untouched by it. Assertion flagged in simulation.
- mdu_op 0 or 7 with start=1: no effect.
- Reset mid-operation: aborts, clears busy, leaves hi/lo at 0; the pending result is discarded.
- busy is registered; there is no combinational path from start to busy. The hazard unit ORs start itself when it forms delayMDU.

Decomposition:
- Shared header mdu_defs: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO op codes, and the 4-bit cycle-count width.
- The same header is used by the D-stage decoder and by the hazard logic that detects MDU instructions in D.
- No sub-module required. The counter/state machine and result datapath stay in mdu_unit (~150 lines).

Test Plan:
- Reset then idle: reset=1 mid-cycle -> hi=lo=0, busy=0 immediately, before any clock edge; mdu_out=0 for both rd_sel values.
- mult, src_a=0xFFFFFFFF, src_b=2 -> busy=1 for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFE. Repeat as multu -> hi=0x00000001, lo=0xFFFFFFFE.
- div, src_a=-7, src_b=2 -> busy=1 for 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). divu, 7/2 -> lo=3, hi=1.
- divu, src_b=0, with hi=0x11, lo=0x22 preloaded via mthi/mtlo -> busy for 10 cycles; hi/lo remain 0x11/0x22. mthi/mtlo themselves must show busy=0.
- mult started, src_a/src_b toggled to random values during busy, plus a spurious start with div -> final hi/lo equal the original mult product only.
- reset asserted in cycle 3 of a div -> busy=0 at once; hi=lo=0; a following mult completes normally with correct 5-cycle latency.
